// File: rtl/fir_pkg.sv
// Shared widths, derived output format and FSM encoding for the serial-MAC FIR core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

    // Default arithmetic format
    localparam int N_TAPS = 8;
    localparam int NB_X   = 8;
    localparam int NBF_X  = 6;
    localparam int NB_C   = 8;
    localparam int NBF_C  = 6;
    localparam int NB_G   = 4;

    // Full-precision output: product width plus guard bits, fraction is the sum of both
    localparam int NB_Y   = NB_X + NB_C + NB_G;
    localparam int NBF_Y  = NBF_X + NBF_C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Tap counter width; never narrower than one bit
    function automatic int tap_cnt_width(input int n_taps);
        return (n_taps <= 1) ? 1 : $clog2(n_taps);
    endfunction

endpackage

// File: rtl/fir_serial_mac_if.sv
// Sample-in / result-out bundle of the serial-MAC FIR core.
// Latency: n/a (wiring only).
// Backpressure: i_valid/o_ready on the input side; o_valid is a pulse with no ready.
//   i_coeffs : packed coefficients, c[k] = i_coeffs[k*NB_C +: NB_C]
//   i_data/i_valid/o_ready : input sample handshake
//   o_data/o_valid : filter result and its one-cycle qualifier
interface fir_serial_mac_if #(
    parameter int N_TAPS = fir_pkg::N_TAPS,
    parameter int NB_X   = fir_pkg::NB_X,
    parameter int NB_C   = fir_pkg::NB_C,
    parameter int NB_Y   = fir_pkg::NB_Y
) ();

    logic [N_TAPS*NB_C-1:0] i_coeffs;
    logic [NB_X-1:0]        i_data;
    logic                   i_valid;
    logic                   o_ready;
    logic [NB_Y-1:0]        o_data;
    logic                   o_valid;

    // Filter core side
    modport slave (
        input  i_coeffs,
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_data,
        output o_valid
    );

    // Sample producer / result consumer side
    modport master (
        output i_coeffs,
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_data,
        input  o_valid
    );

endinterface

// File: rtl/fir_delay_line.sv
// N_TAPS-deep sample shift register with one combinational indexed read port.
// Latency: shift visible one cycle after shift_en; read is combinational.
// Backpressure: none; shifts whenever shift_en is high.
//   core_clk, arst_n : clock, asynchronous active-low clear of all slots
//   shift_en, din    : push din into slot 0, oldest slot falls off the end
//   rd_idx, rd_dat   : rd_dat = slot[rd_idx] (slot k holds x[n-k])
module fir_delay_line #(
    parameter int N_TAPS = 8,
    parameter int NB_X   = 8,
    parameter int KW     = 3
) (
    input  logic            core_clk,
    input  logic            arst_n,
    input  logic            shift_en,
    input  logic [NB_X-1:0] din,
    input  logic [KW-1:0]   rd_idx,
    output logic [NB_X-1:0] rd_dat
);

    logic [NB_X-1:0] taps [N_TAPS];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                taps[i] <= '0;
            end
        end else if (shift_en) begin
            taps[0] <= din;
            for (int i = 1; i < N_TAPS; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign rd_dat = taps[rd_idx];

endmodule

// File: rtl/fir_serial_mac.sv
// Direct-form FIR computing one tap per clock through a single multiplier/accumulator.
// Latency: accept at edge 0 gives o_valid in cycle N_TAPS+1; one sample per N_TAPS+2 cycles.
// Backpressure: o_ready only in IDLE; no output backpressure, result must be taken on o_valid.
//   i_clock, i_reset_n : clock, asynchronous active-low reset
//   bus (slave)        : coefficients, sample handshake, result and its valid pulse
module fir_serial_mac #(
    parameter int N_TAPS = fir_pkg::N_TAPS,
    parameter int NB_X   = fir_pkg::NB_X,
    parameter int NB_C   = fir_pkg::NB_C,
    parameter int NB_G   = fir_pkg::NB_G,
    parameter int NB_Y   = NB_X + NB_C + NB_G
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    fir_serial_mac_if.slave bus
);

    import fir_pkg::*;

    localparam int            KW     = tap_cnt_width(N_TAPS);
    localparam int            NB_P   = NB_X + NB_C;
    localparam logic [KW-1:0] K_LAST = KW'(N_TAPS - 1);

    if ((N_TAPS < 2) || (N_TAPS > 16) || ((2 ** NB_G) < N_TAPS) || (NB_Y != NB_P + NB_G)) begin : g_bad_cfg
        $error("fir_serial_mac: illegal N_TAPS/NB_G/NB_Y combination");
    end

    state_t                 state;
    state_t                 state_nxt;
    logic [KW-1:0]          k;
    logic signed [NB_Y-1:0] acc;
    logic [NB_Y-1:0]        y_q;

    logic [NB_X-1:0]        x_k;
    logic [NB_C-1:0]        c_k;
    logic signed [NB_P-1:0] prod;
    logic signed [NB_Y-1:0] acc_sum;
    logic                   accept;

    // Sample capture happens only while ready, so MAC/DONE-time offers are dropped
    assign accept = (state == IDLE) && bus.i_valid;

    fir_delay_line #(
        .N_TAPS (N_TAPS),
        .NB_X   (NB_X),
        .KW     (KW)
    ) u_delay_line (
        .core_clk (i_clock),
        .arst_n   (i_reset_n),
        .shift_en (accept),
        .din      (bus.i_data),
        .rd_idx   (k),
        .rd_dat   (x_k)
    );

    assign c_k     = bus.i_coeffs[k*NB_C +: NB_C];
    assign prod    = $signed(x_k) * $signed(c_k);
    // Guard bits absorb the growth of N_TAPS products, so no saturation is needed
    assign acc_sum = acc + {{NB_G{prod[NB_P-1]}}, prod};

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.o_ready = 1'b0;
        bus.o_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_valid) begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (k == K_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.o_valid = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc <= '0;
            k   <= '0;
            y_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        acc <= '0;
                        k   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    // Result is registered on the last tap so it is already stable
                    // throughout the DONE cycle that carries o_valid
                    if (k == K_LAST) begin
                        y_q <= acc_sum;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_data = y_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Self-checking bench for fir_serial_mac: reference-model scoreboard plus fixed expectations.
// Latency: checks o_valid 9 cycles after each accept with default widths.
// Backpressure: drives i_valid against o_ready; consumes every o_valid pulse.
module tb_fir_serial_mac;
    import fir_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fir_serial_mac_if bus ();

    fir_serial_mac dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [NB_C-1:0] coef [N_TAPS];
    logic [NB_X-1:0] mdl  [N_TAPS];
    logic [NB_Y-1:0] exp_q [$];
    logic [NB_Y-1:0] last_exp = '0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic load_coeffs();
        for (int k = 0; k < N_TAPS; k++) begin
            bus.i_coeffs[k*NB_C +: NB_C] = coef[k];
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < N_TAPS; k++) mdl[k] = '0;
        exp_q.delete();
    endtask

    // Golden model: shift the new sample in and form the full-precision dot product
    function automatic logic [NB_Y-1:0] model_accept(input logic [NB_X-1:0] x);
        logic signed [31:0] s;
        s = 0;
        for (int k = N_TAPS - 1; k > 0; k--) mdl[k] = mdl[k-1];
        mdl[0] = x;
        for (int k = 0; k < N_TAPS; k++) begin
            s = s + $signed(mdl[k]) * $signed(coef[k]);
        end
        return s[NB_Y-1:0];
    endfunction

    // Called on a negedge; returns on the negedge after the accepting edge
    task automatic send(input logic [NB_X-1:0] x, output bit ok);
        bus.i_data  = x;
        bus.i_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (bus.o_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) exp_q.push_back(model_accept(x));
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    // lat counts negedges since the accepting cycle
    task automatic wait_out(output bit got, output int lat);
        got = 1'b0;
        lat = 1;
        for (int t = 0; t < 40; t++) begin
            if (bus.o_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_coeffs = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        n_checks++;
        if (bus.o_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.o_ready);
        else n_pass++;
        n_checks++;
        if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.o_valid);
        else n_pass++;
        n_checks++;
        if (bus.o_data !== '0) $display("FAIL reset_data: got %h expected 00000", bus.o_data);
        else n_pass++;
    endtask

    task automatic test_impulse();
        logic [NB_Y-1:0] tbl [8];
        logic [NB_Y-1:0] e;
        bit ok, got;
        int lat;
        tbl = '{20'h01000, 20'h00800, 20'h00400, 20'h00200,
                20'hFFE00, 20'hFFC00, 20'hFF800, 20'hFF000};
        coef = '{8'h40, 8'h20, 8'h10, 8'h08, 8'hF8, 8'hF0, 8'hE0, 8'hC0};
        load_coeffs();
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? 8'h40 : 8'h00, ok);
            wait_out(got, lat);
            n_checks++;
            if (!ok || !got) $display("FAIL impulse_handshake[%0d]: accepted %b output %b expected 1 1", i, ok, got);
            else n_pass++;
            if (got) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                last_exp = e;
                n_checks++;
                if (bus.o_data !== e) $display("FAIL impulse_model[%0d]: got %h expected %h", i, bus.o_data, e);
                else n_pass++;
                n_checks++;
                if (bus.o_data !== tbl[i]) $display("FAIL impulse_table[%0d]: got %h expected %h", i, bus.o_data, tbl[i]);
                else n_pass++;
                n_checks++;
                if (lat != 9) $display("FAIL impulse_latency[%0d]: got %0d expected 9", i, lat);
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_max_magnitude();
        logic [NB_Y-1:0] e;
        logic [NB_X-1:0] xs;
        bit ok, got;
        int lat;
        for (int k = 0; k < N_TAPS; k++) coef[k] = 8'h80;
        load_coeffs();
        for (int i = 0; i < 16; i++) begin
            xs = (i < 8) ? 8'h80 : 8'h7F;
            send(xs, ok);
            wait_out(got, lat);
            n_checks++;
            if (!ok || !got) $display("FAIL maxmag_handshake[%0d]: accepted %b output %b expected 1 1", i, ok, got);
            else n_pass++;
            if (got) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                last_exp = e;
                n_checks++;
                if (bus.o_data !== e) $display("FAIL maxmag_model[%0d]: got %h expected %h", i, bus.o_data, e);
                else n_pass++;
                if (i == 7) begin
                    n_checks++;
                    if (bus.o_data !== 20'h20000) $display("FAIL maxmag_pos: got %h expected 20000", bus.o_data);
                    else n_pass++;
                end
                if (i == 15) begin
                    n_checks++;
                    if (bus.o_data !== 20'hE0400) $display("FAIL maxmag_neg: got %h expected E0400", bus.o_data);
                    else n_pass++;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [NB_Y-1:0] e;
        int last_rdy = -1;
        int accepts  = 0;
        int outs     = 0;
        bit got;
        int lat;
        coef = '{8'h40, 8'h20, 8'h10, 8'h08, 8'hF8, 8'hF0, 8'hE0, 8'hC0};
        load_coeffs();
        bus.i_valid = 1'b1;
        for (int c = 0; c < 120; c++) begin
            bus.i_data = 8'($urandom);
            if (bus.o_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                last_exp = e;
                outs++;
                n_checks++;
                if (bus.o_data !== e) $display("FAIL b2b_data[%0d]: got %h expected %h", outs, bus.o_data, e);
                else n_pass++;
            end
            if (bus.o_ready === 1'b1) begin
                exp_q.push_back(model_accept(bus.i_data));
                accepts++;
                if (last_rdy >= 0) begin
                    n_checks++;
                    if (c - last_rdy != 10) $display("FAIL b2b_ready_period: got %0d expected 10", c - last_rdy);
                    else n_pass++;
                end
                last_rdy = c;
            end
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        while (exp_q.size() > 0) begin
            wait_out(got, lat);
            n_checks++;
            if (!got) begin
                $display("FAIL b2b_drain: output %b expected 1", got);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                outs++;
                if (bus.o_data !== e) $display("FAIL b2b_drain_data: got %h expected %h", bus.o_data, e);
                else n_pass++;
                @(negedge clk);
            end
        end
        n_checks++;
        if (accepts != 12) $display("FAIL b2b_accepts: got %0d expected 12", accepts);
        else n_pass++;
        n_checks++;
        if (outs != accepts) $display("FAIL b2b_outputs: got %0d expected %0d", outs, accepts);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [NB_Y-1:0] e;
        bit ok, got;
        int lat;
        int vld_seen = 0;
        coef = '{8'h40, 8'h20, 8'h10, 8'h08, 8'hF8, 8'hF0, 8'hE0, 8'hC0};
        load_coeffs();
        send(8'h7F, ok);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.o_data !== '0) $display("FAIL midrst_data: got %h expected 00000", bus.o_data);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        for (int c = 0; c < 12; c++) begin
            if (bus.o_valid !== 1'b0) vld_seen++;
            @(negedge clk);
        end
        n_checks++;
        if (vld_seen != 0) $display("FAIL midrst_no_valid: got %0d pulses expected 0", vld_seen);
        else n_pass++;
        n_checks++;
        if (bus.o_data !== '0) $display("FAIL midrst_data_after: got %h expected 00000", bus.o_data);
        else n_pass++;
        send(8'h40, ok);
        wait_out(got, lat);
        n_checks++;
        if (!ok || !got) $display("FAIL midrst_handshake: accepted %b output %b expected 1 1", ok, got);
        else n_pass++;
        if (got) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            last_exp = e;
            n_checks++;
            if (bus.o_data !== 20'h01000) $display("FAIL midrst_impulse: got %h expected 01000", bus.o_data);
            else n_pass++;
            n_checks++;
            if (bus.o_data !== e) $display("FAIL midrst_model: got %h expected %h", bus.o_data, e);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_idle_stability();
        int bad_vld = 0;
        int bad_rdy = 0;
        int bad_dat = 0;
        bus.i_valid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            bus.i_data = 8'($urandom);
            if (bus.o_valid !== 1'b0) bad_vld++;
            if (bus.o_ready !== 1'b1) bad_rdy++;
            if (bus.o_data !== last_exp) bad_dat++;
            @(negedge clk);
        end
        n_checks++;
        if (bad_vld != 0) $display("FAIL idle_valid: got %0d cycles high expected 0", bad_vld);
        else n_pass++;
        n_checks++;
        if (bad_rdy != 0) $display("FAIL idle_ready: got %0d cycles low expected 0", bad_rdy);
        else n_pass++;
        n_checks++;
        if (bad_dat != 0) $display("FAIL idle_data_hold: got %0d cycles changed expected 0 (hold %h)", bad_dat, last_exp);
        else n_pass++;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_coeffs = '0;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_max_magnitude();
        test_back_to_back();
        test_mid_reset();
        test_idle_stability();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
